// File: rtl/baud_rate_ctrl_if.sv
// Handshake bundle between the baud-rate controller and the CPU config port,
// baud decoder and TX/RX engines. cfg_err exists only with BAUD_RANGE_CHK_EN.
interface baud_rate_ctrl_if;
    logic [3:0]  baud_sel;
    logic        baud_wr;
    logic        tx_busy;
    logic        rx_busy;
    logic [18:0] k_in;
    logic [3:0]  baud_cur;
    logic        tick;
    logic        half_tick;
    logic        cfg_pend;
    logic        cfg_ack;
`ifdef BAUD_RANGE_CHK_EN
    logic        cfg_err;

    modport slave (
        input  baud_sel, baud_wr, tx_busy, rx_busy, k_in,
        output baud_cur, tick, half_tick, cfg_pend, cfg_ack, cfg_err
    );
    modport master (
        output baud_sel, baud_wr, tx_busy, rx_busy, k_in,
        input  baud_cur, tick, half_tick, cfg_pend, cfg_ack, cfg_err
    );
`else
    modport slave (
        input  baud_sel, baud_wr, tx_busy, rx_busy, k_in,
        output baud_cur, tick, half_tick, cfg_pend, cfg_ack
    );
    modport master (
        output baud_sel, baud_wr, tx_busy, rx_busy, k_in,
        input  baud_cur, tick, half_tick, cfg_pend, cfg_ack
    );
`endif
endinterface

// File: rtl/baud_rate_ctrl.sv
// UART baud-rate sequencer: owns the active baud code, latches divisor K, and
// generates tick/half_tick. Optional BAUD_RANGE_CHK_EN rejects codes above 4'hB.
module baud_rate_ctrl #(
    parameter logic [3:0]  RESET_BAUD = 4'h8,
    parameter logic [18:0] RESET_K    = 19'd868
) (
    input  logic             clk,
    input  logic             reset_n,
    baud_rate_ctrl_if.slave  bus
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [3:0]  pend_sel, baud_cur_r;
    logic [18:0] k_reg, cnt, k_eff, k_last, half_last;
    logic        tick_r, half_r, pend_r, ack_r;
    logic        wr_ok, idle;
`ifdef BAUD_RANGE_CHK_EN
    logic        err_r;
    logic        wr_bad;
`endif

    always_comb begin
        // Divisors below 2 cannot produce a distinct mid-point, so clamp to 2.
        k_eff     = (k_reg < 19'd2) ? 19'd2 : k_reg;
        k_last    = k_eff - 19'd1;
        half_last = (k_eff >> 1) - 19'd1;
        idle      = !bus.tx_busy && !bus.rx_busy;
`ifdef BAUD_RANGE_CHK_EN
        wr_ok     = bus.baud_wr && (bus.baud_sel <= 4'hB);
        wr_bad    = bus.baud_wr && (bus.baud_sel > 4'hB);
`else
        wr_ok     = bus.baud_wr;
`endif
        state_nxt = state;
        case (state)
            RUN:     if (wr_ok) state_nxt = PEND;
            PEND:    if (idle) state_nxt = APPLY;
            APPLY:   state_nxt = wr_ok ? PEND : RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            baud_cur_r <= RESET_BAUD;
            k_reg      <= RESET_K;
            cnt        <= '0;
            pend_sel   <= '0;
            tick_r     <= 1'b0;
            half_r     <= 1'b0;
            pend_r     <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend_r <= (state_nxt == PEND);
            ack_r  <= (state == APPLY);
            if (wr_ok)
                pend_sel <= bus.baud_sel;
            // A write landing on the idle cycle takes priority over the older pending code.
            if (state == PEND && idle)
                baud_cur_r <= wr_ok ? bus.baud_sel : pend_sel;
            if (state == APPLY) begin
                k_reg  <= bus.k_in;
                cnt    <= '0;
                tick_r <= 1'b0;
                half_r <= 1'b0;
            end else begin
                cnt    <= (cnt >= k_last) ? 19'd0 : cnt + 19'd1;
                tick_r <= (cnt >= k_last);
                half_r <= (cnt == half_last);
            end
        end
    end

`ifdef BAUD_RANGE_CHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_r <= 1'b0;
        else
            err_r <= wr_bad;
    end

    assign bus.cfg_err = err_r;
`endif

    assign bus.baud_cur  = baud_cur_r;
    assign bus.tick      = tick_r;
    assign bus.half_tick = half_r;
    assign bus.cfg_pend  = pend_r;
    assign bus.cfg_ack   = ack_r;

endmodule
